// File: rtl/controle_medicao_hcsr04_pkg.sv
// Shared state codes and default timing constants for the HC-SR04 measurement scheduler.
package controle_medicao_hcsr04_pkg;

    localparam int CLOCK_HZ       = 50_000_000;
    localparam int PERIODO_PADRAO = 5_000_000;  // 100 ms
    localparam int TIMEOUT_PADRAO = 1_500_000;  // 30 ms
    localparam int MEDIR_PADRAO   = 5;
    localparam int N_AMOSTRAS     = 4;

    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        ESPERA       = 4'd1,
        PULSO        = 4'd2,
        AGUARDA      = 4'd3,
        REGISTRA     = 4'd4,
        MEDIA        = 4'd5,
        RESET_SENSOR = 4'd6
    } estado_t;

endpackage

// File: rtl/controle_medicao_hcsr04_bcd3_para_bin.sv
// Combinational 3-digit BCD to binary conversion with a digit-out-of-range flag.
module bcd3_para_bin (
    input  logic [11:0] bcd,
    output logic [9:0]  bin,
    output logic        invalido
);

    logic [3:0] d2, d1, d0;

    assign d2 = bcd[11:8];
    assign d1 = bcd[7:4];
    assign d0 = bcd[3:0];

    assign invalido = (d2 > 4'd9) || (d1 > 4'd9) || (d0 > 4'd9);
    // Value is meaningless when invalido is set; callers discard it.
    assign bin = 10'(d2) * 10'd100 + 10'(d1) * 10'd10 + 10'(d0);

endmodule

// File: rtl/controle_medicao_hcsr04.sv
// Periodic HC-SR04 measurement scheduler: request, timeout recovery, BCD capture and 4-sample average.
module controle_medicao_hcsr04
    import controle_medicao_hcsr04_pkg::*;
#(
    parameter int PERIODO_CICLOS = PERIODO_PADRAO,
    parameter int TIMEOUT_CICLOS = TIMEOUT_PADRAO,
    parameter int MEDIR_CICLOS   = MEDIR_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ligar,
    input  logic [9:0]  limiar,
    input  logic        pronto_sensor,
    input  logic [11:0] medida_sensor,
    output logic        medir,
    output logic        reset_sensor,
    output logic [9:0]  distancia,
    output logic        valida,
    output logic        acima_limiar,
    output logic        nova_amostra,
    output logic        erro_timeout,
    output logic        erro_medida,
    output logic [3:0]  db_estado
);

    localparam int WP = $clog2(PERIODO_CICLOS);
    localparam int WT = $clog2(TIMEOUT_CICLOS);

    estado_t        estado, estado_prox;
    logic [WP-1:0]  cont_periodo;
    logic [WT-1:0]  cont_timeout;
    logic           cont_rst;
    logic           pronto_ant;
    logic [1:0]     cont_timeouts;
    logic [9:0]     buffer [N_AMOSTRAS];
    logic [1:0]     ptr;
    logic [2:0]     n_amostras;

    logic [9:0]     medida_bin;
    logic           medida_invalida;
    logic           borda, fim_pulso, estourou, fim_periodo, inicio;
    logic           ev_timeout, aceita, rejeita, atualiza, limpa;
    logic [11:0]    soma;
    logic           valida_prox, acima_prox;
    logic [9:0]     distancia_prox;

    bcd3_para_bin u_conv (
        .bcd      (medida_sensor),
        .bin      (medida_bin),
        .invalido (medida_invalida)
    );

    assign borda       = pronto_sensor && !pronto_ant;
    assign fim_pulso   = (cont_timeout == WT'(MEDIR_CICLOS - 1));
    assign estourou    = (cont_timeout == WT'(TIMEOUT_CICLOS - 1));
    assign fim_periodo = (cont_periodo == WP'(PERIODO_CICLOS - 1));
    assign inicio      = (estado_prox == PULSO) && (estado != PULSO);
    assign db_estado   = estado;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        estado_prox = estado;
        if (!ligar) begin
            estado_prox = INICIAL;
        end else begin
            case (estado)
                INICIAL:      estado_prox = PULSO;
                ESPERA:       if (fim_periodo) estado_prox = PULSO;
                PULSO:        if (fim_pulso) estado_prox = AGUARDA;
                AGUARDA: begin
                    // The pronto edge takes priority over a coincident timeout.
                    if (borda)         estado_prox = REGISTRA;
                    else if (estourou) estado_prox = RESET_SENSOR;
                end
                REGISTRA:     estado_prox = medida_invalida ? ESPERA : MEDIA;
                MEDIA:        estado_prox = ESPERA;
                RESET_SENSOR: if (cont_rst) estado_prox = ESPERA;
                default:      estado_prox = INICIAL;
            endcase
        end
    end

    always_comb begin
        ev_timeout = ligar && (estado == AGUARDA) && !borda && estourou;
        aceita     = ligar && (estado == REGISTRA) && !medida_invalida;
        rejeita    = ligar && (estado == REGISTRA) && medida_invalida;
        atualiza   = ligar && (estado == MEDIA) && (n_amostras == 3'(N_AMOSTRAS));
        limpa      = ev_timeout && (cont_timeouts >= 2'd2);

        soma = '0;
        for (int i = 0; i < N_AMOSTRAS; i++) soma = soma + 12'(buffer[i]);

        valida_prox    = limpa ? 1'b0 : (atualiza ? 1'b1 : valida);
        distancia_prox = atualiza ? soma[11:2] : distancia;
        acima_prox     = valida_prox && (distancia_prox > limiar);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= INICIAL;
            cont_periodo <= '0;
            cont_timeout <= '0;
            cont_rst     <= 1'b0;
            pronto_ant   <= 1'b0;
            medir        <= 1'b0;
            reset_sensor <= 1'b0;
        end else begin
            estado       <= estado_prox;
            pronto_ant   <= pronto_sensor;
            cont_rst     <= (estado == RESET_SENSOR) && (estado_prox == RESET_SENSOR);
            medir        <= (estado_prox == PULSO);
            reset_sensor <= (estado_prox == RESET_SENSOR);

            // Both counters saturate so an overrun leaves ESPERA immediately.
            if (estado_prox == INICIAL || inicio) begin
                cont_periodo <= '0;
                cont_timeout <= '0;
            end else begin
                if (!fim_periodo) cont_periodo <= cont_periodo + 1'b1;
                if (!estourou)    cont_timeout <= cont_timeout + 1'b1;
            end
        end
    end

    // NOTE: the sample buffer is reset because the average must read 0 after reset, not X.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_AMOSTRAS; i++) buffer[i] <= '0;
            ptr           <= '0;
            n_amostras    <= '0;
            cont_timeouts <= '0;
            erro_timeout  <= 1'b0;
            erro_medida   <= 1'b0;
            distancia     <= '0;
            valida        <= 1'b0;
            acima_limiar  <= 1'b0;
            nova_amostra  <= 1'b0;
        end else begin
            distancia    <= distancia_prox;
            valida       <= valida_prox;
            acima_limiar <= acima_prox;
            nova_amostra <= atualiza;

            if (aceita) begin
                buffer[ptr]   <= medida_bin;
                ptr           <= ptr + 1'b1;
                if (n_amostras != 3'(N_AMOSTRAS)) n_amostras <= n_amostras + 1'b1;
                cont_timeouts <= '0;
                erro_timeout  <= 1'b0;
                erro_medida   <= 1'b0;
            end
            if (rejeita) erro_medida <= 1'b1;
            if (ev_timeout) begin
                erro_timeout <= 1'b1;
                if (cont_timeouts != 2'd3) cont_timeouts <= cont_timeouts + 1'b1;
            end
            if (limpa) begin
                for (int i = 0; i < N_AMOSTRAS; i++) buffer[i] <= '0;
                ptr        <= '0;
                n_amostras <= '0;
            end
        end
    end

endmodule

// File: tb/tb_controle_medicao_hcsr04.sv
// Directed bench for controle_medicao_hcsr04 with scaled timing (MEDIR 5, TIMEOUT 200, PERIODO 500).
module tb_controle_medicao_hcsr04;

    localparam int MEDIR   = 5;
    localparam int TIMEOUT = 200;
    localparam int PERIODO = 500;

    logic        clock = 1'b0;
    logic        reset;
    logic        ligar;
    logic [9:0]  limiar;
    logic        pronto_sensor;
    logic [11:0] medida_sensor;
    logic        medir, reset_sensor, valida, acima_limiar, nova_amostra;
    logic        erro_timeout, erro_medida;
    logic [9:0]  distancia;
    logic [3:0]  db_estado;

    int erros  = 0;
    int checks = 0;

    controle_medicao_hcsr04 #(
        .PERIODO_CICLOS (PERIODO),
        .TIMEOUT_CICLOS (TIMEOUT),
        .MEDIR_CICLOS   (MEDIR)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ligar         (ligar),
        .limiar        (limiar),
        .pronto_sensor (pronto_sensor),
        .medida_sensor (medida_sensor),
        .medir         (medir),
        .reset_sensor  (reset_sensor),
        .distancia     (distancia),
        .valida        (valida),
        .acima_limiar  (acima_limiar),
        .nova_amostra  (nova_amostra),
        .erro_timeout  (erro_timeout),
        .erro_medida   (erro_medida),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Bounded wait for a measurement request; returns cycles waited.
    task automatic espera_medir(output int ciclos);
        ciclos = 0;
        while (medir !== 1'b1 && ciclos < 1100) begin
            tick();
            ciclos++;
        end
        checks++;
        if (medir !== 1'b1) begin
            erros++;
            $display("FAIL espera_medir: medir=%b after %0d cycles, required 1", medir, ciclos);
        end
    endtask

    // Sensor model: answers a request with a pronto pulse; returns nova_amostra 2,3,4 cycles after the rise.
    task automatic medicao(input logic [11:0] valor, output logic [2:0] nova_obs);
        int c;
        espera_medir(c);
        repeat (10) tick();
        medida_sensor = valor;
        pronto_sensor = 1'b1;
        tick(); tick(); nova_obs[2] = nova_amostra;
        tick();         nova_obs[1] = nova_amostra;
        tick();         nova_obs[0] = nova_amostra;
        pronto_sensor = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; ligar = 1'b0; pronto_sensor = 1'b0;
        limiar = 10'd1023; medida_sensor = '0;
        #2;
        checks++;
        if ({medir, reset_sensor, distancia, valida, acima_limiar, nova_amostra,
             erro_timeout, erro_medida, db_estado} !== '0) begin
            erros++;
            $display("FAIL reset_outputs: medir=%b rs=%b dist=%0d val=%b est=%0d, required all 0",
                     medir, reset_sensor, distancia, valida, db_estado);
        end
        #10 reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (db_estado !== 4'd0 || medir !== 1'b0) begin
            erros++;
            $display("FAIL idle_without_ligar: estado=%0d medir=%b, required 0/0", db_estado, medir);
        end
    endtask

    task automatic test_media();
        logic [11:0] vals [4] = '{12'h005, 12'h004, 12'h390, 12'h390};
        logic [2:0]  nova;
        ligar = 1'b1;
        tick();
        checks++;
        if (medir !== 1'b1 || db_estado !== 4'd2) begin
            erros++;
            $display("FAIL medir_start: medir=%b estado=%0d, required 1/2", medir, db_estado);
        end
        for (int i = 0; i < 4; i++) begin
            medicao(vals[i], nova);
            checks++;
            if (nova !== ((i == 3) ? 3'b010 : 3'b000) || valida !== (i == 3)) begin
                erros++;
                $display("FAIL media_sample%0d: nova=%b valida=%b, required %b/%b",
                         i, nova, valida, (i == 3) ? 3'b010 : 3'b000, (i == 3));
            end
        end
        checks++;
        if (distancia !== 10'd197 || acima_limiar !== 1'b0) begin
            erros++;
            $display("FAIL media_value: distancia=%0d acima=%b, required 197/0", distancia, acima_limiar);
        end
    endtask

    task automatic test_timeout();
        int c;
        limiar = 10'd100;
        tick();
        checks++;
        if (acima_limiar !== 1'b1) begin
            erros++;
            $display("FAIL acima_197_100: acima=%b, required 1", acima_limiar);
        end
        espera_medir(c);
        repeat (TIMEOUT - 1) tick();
        checks++;
        if (erro_timeout !== 1'b0 || reset_sensor !== 1'b0) begin
            erros++;
            $display("FAIL timeout_early: erro=%b rs=%b, required 0/0", erro_timeout, reset_sensor);
        end
        tick();
        checks++;
        if (erro_timeout !== 1'b1 || reset_sensor !== 1'b1 || db_estado !== 4'd6) begin
            erros++;
            $display("FAIL timeout_hit: erro=%b rs=%b estado=%0d, required 1/1/6",
                     erro_timeout, reset_sensor, db_estado);
        end
        tick();
        checks++;
        if (reset_sensor !== 1'b1) begin
            erros++;
            $display("FAIL reset_sensor_cycle2: rs=%b, required 1", reset_sensor);
        end
        tick();
        checks++;
        if (reset_sensor !== 1'b0 || db_estado !== 4'd1 || valida !== 1'b1) begin
            erros++;
            $display("FAIL reset_sensor_end: rs=%b estado=%0d valida=%b, required 0/1/1",
                     reset_sensor, db_estado, valida);
        end
        espera_medir(c);
        checks++;
        if (c != PERIODO - (TIMEOUT + 2)) begin
            erros++;
            $display("FAIL period_after_timeout: waited=%0d, required %0d", c, PERIODO - (TIMEOUT + 2));
        end
    endtask

    task automatic test_tres_timeouts();
        int c;
        logic [2:0] nova;
        for (int i = 0; i < 2; i++) begin
            espera_medir(c);
            repeat (TIMEOUT + 2) tick();
        end
        checks++;
        if (valida !== 1'b0 || acima_limiar !== 1'b0 || erro_timeout !== 1'b1) begin
            erros++;
            $display("FAIL three_timeouts: valida=%b acima=%b erro=%b, required 0/0/1",
                     valida, acima_limiar, erro_timeout);
        end
        medicao(12'h100, nova);
        checks++;
        if (nova !== 3'b000 || valida !== 1'b0 || erro_timeout !== 1'b0) begin
            erros++;
            $display("FAIL refill_first: nova=%b valida=%b erro=%b, required 000/0/0",
                     nova, valida, erro_timeout);
        end
        for (int i = 0; i < 3; i++) begin
            medicao(12'h150, nova);
            checks++;
            if (nova !== ((i == 2) ? 3'b010 : 3'b000) || valida !== (i == 2)) begin
                erros++;
                $display("FAIL refill_sample%0d: nova=%b valida=%b", i, nova, valida);
            end
        end
        checks++;
        if (distancia !== 10'd137 || acima_limiar !== 1'b1) begin
            erros++;
            $display("FAIL refill_value: distancia=%0d acima=%b, required 137/1", distancia, acima_limiar);
        end
    endtask

    task automatic test_limiar();
        logic [2:0] nova;
        medicao(12'h150, nova);
        checks++;
        if (nova !== 3'b010 || distancia !== 10'd150 || acima_limiar !== 1'b1) begin
            erros++;
            $display("FAIL all_150: nova=%b distancia=%0d acima=%b, required 010/150/1",
                     nova, distancia, acima_limiar);
        end
        limiar = 10'd150;
        checks++;
        if (acima_limiar !== 1'b1) begin
            erros++;
            $display("FAIL limiar_same_cycle: acima=%b, required 1", acima_limiar);
        end
        tick();
        checks++;
        if (acima_limiar !== 1'b0) begin
            erros++;
            $display("FAIL limiar_150: acima=%b, required 0", acima_limiar);
        end
    endtask

    task automatic test_erro_medida();
        logic [2:0] nova;
        medicao(12'h3A0, nova);
        checks++;
        if (nova !== 3'b000 || erro_medida !== 1'b1 || distancia !== 10'd150 || valida !== 1'b1) begin
            erros++;
            $display("FAIL bad_bcd: nova=%b erro=%b distancia=%0d valida=%b, required 000/1/150/1",
                     nova, erro_medida, distancia, valida);
        end
        medicao(12'h150, nova);
        checks++;
        if (nova !== 3'b010 || erro_medida !== 1'b0 || distancia !== 10'd150) begin
            erros++;
            $display("FAIL after_bad_bcd: nova=%b erro=%b distancia=%0d, required 010/0/150",
                     nova, erro_medida, distancia);
        end
    endtask

    task automatic test_coincidente();
        int c;
        espera_medir(c);
        repeat (TIMEOUT - 1) tick();
        medida_sensor = 12'h150;
        pronto_sensor = 1'b1;
        tick();
        checks++;
        if (db_estado !== 4'd4 || reset_sensor !== 1'b0) begin
            erros++;
            $display("FAIL coincident_edge: estado=%0d rs=%b, required 4/0", db_estado, reset_sensor);
        end
        tick(); tick();
        checks++;
        if (nova_amostra !== 1'b1 || erro_timeout !== 1'b0) begin
            erros++;
            $display("FAIL coincident_accept: nova=%b erro=%b, required 1/0", nova_amostra, erro_timeout);
        end
        tick();
        pronto_sensor = 1'b0;
        checks++;
        if (reset_sensor !== 1'b0 || db_estado !== 4'd1) begin
            erros++;
            $display("FAIL coincident_no_reset: rs=%b estado=%0d, required 0/1", reset_sensor, db_estado);
        end
    endtask

    task automatic test_desliga();
        int c;
        espera_medir(c);
        repeat (10) tick();
        checks++;
        if (db_estado !== 4'd3) begin
            erros++;
            $display("FAIL in_aguarda: estado=%0d, required 3", db_estado);
        end
        ligar = 1'b0;
        tick();
        checks++;
        if (db_estado !== 4'd0 || medir !== 1'b0 || valida !== 1'b1 || distancia !== 10'd150) begin
            erros++;
            $display("FAIL desliga: estado=%0d medir=%b valida=%b distancia=%0d, required 0/0/1/150",
                     db_estado, medir, valida, distancia);
        end
        ligar = 1'b1;
        tick();
        checks++;
        if (medir !== 1'b1 || db_estado !== 4'd2) begin
            erros++;
            $display("FAIL religa: medir=%b estado=%0d, required 1/2", medir, db_estado);
        end
    endtask

    task automatic test_reset_async();
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({medir, reset_sensor, distancia, valida, acima_limiar, nova_amostra,
             erro_timeout, erro_medida, db_estado} !== '0) begin
            erros++;
            $display("FAIL async_reset: medir=%b dist=%0d val=%b est=%0d, required all 0",
                     medir, distancia, valida, db_estado);
        end
        tick();
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_media();
        test_timeout();
        test_tres_timeouts();
        test_limiar();
        test_erro_medida();
        test_coincidente();
        test_desliga();
        test_reset_async();
        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule
